// File: rtl/regfile_wordline_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | regfile_wordline_reader: 16-entry register file written via one-hot        |
// | wordline, two combinational read ports with bypass. Revision 1.0           |
// +----------------------------------------------------------------------------+
module regfile_wordline_reader #(
  parameter int WIDTH   = 16,
  parameter bit ZERO_R0 = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [15:0]      Wordline,
  input  logic [WIDTH-1:0] DstData,
  input  logic [3:0]       SrcReg1,
  input  logic [3:0]       SrcReg2,
  output logic [WIDTH-1:0] SrcData1,
  output logic [WIDTH-1:0] SrcData2,
  output logic             wl_err
);

  logic [WIDTH-1:0] r_regs [16];
  logic             r_wl_err;
  logic             w_onehot;
  logic             w_multi;

  // x & (x-1) clears the lowest set bit; zero result means at most one bit set
  assign w_onehot = (Wordline != 16'd0) && ((Wordline & (Wordline - 16'd1)) == 16'd0);
  assign w_multi  = (Wordline != 16'd0) && !w_onehot;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        r_regs[i] <= '0;
      end
      r_wl_err <= 1'b0;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (w_onehot && Wordline[i] && !(ZERO_R0 && (i == 0))) begin
          r_regs[i] <= DstData;
        end
      end
      if (w_multi) begin
        r_wl_err <= 1'b1;
      end
    end
  end

  function automatic logic [WIDTH-1:0] read_port(input logic [3:0] sel);
    logic [WIDTH-1:0] v;
    v = r_regs[sel];
    if (w_onehot && Wordline[sel]) begin
      v = DstData;
    end
    // R0 hard-zero and reset both override storage and bypass
    if ((ZERO_R0 && (sel == 4'd0)) || !rst_n) begin
      v = '0;
    end
    return v;
  endfunction

  assign SrcData1 = read_port(SrcReg1);
  assign SrcData2 = read_port(SrcReg2);
  assign wl_err   = r_wl_err;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wordline_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_regfile_wordline_reader: randomized + directed bench with array model.  |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_regfile_wordline_reader;

  logic        clk;
  logic        rst_n;
  logic [15:0] Wordline;
  logic [15:0] DstData;
  logic [3:0]  SrcReg1;
  logic [3:0]  SrcReg2;
  logic [15:0] SrcData1;
  logic [15:0] SrcData2;
  logic        wl_err;

  int          vecs;
  int          errs;
  logic [15:0] model [16];
  logic        merr;

  regfile_wordline_reader #(.WIDTH(16), .ZERO_R0(1'b1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .Wordline (Wordline),
    .DstData  (DstData),
    .SrcReg1  (SrcReg1),
    .SrcReg2  (SrcReg2),
    .SrcData1 (SrcData1),
    .SrcData2 (SrcData2),
    .wl_err   (wl_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected read value from the architectural rules applied to the model array
  function automatic logic [15:0] exp_rd(input logic [3:0] s);
    if (!rst_n) return 16'h0;
    if (s == 4'd0) return 16'h0;
    if ($countones(Wordline) == 1 && Wordline[s]) return DstData;
    return model[s];
  endfunction

  task automatic tick();
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) model[i] = 16'h0;
      merr = 1'b0;
    end else if ($countones(Wordline) == 1) begin
      for (int i = 1; i < 16; i++) if (Wordline[i]) model[i] = DstData;
    end else if ($countones(Wordline) > 1) begin
      merr = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; Wordline = 16'h0010; DstData = 16'h7777; SrcReg1 = 4'd4; SrcReg2 = 4'd4;
    #1;
    vecs++;
    if (SrcData1 !== 16'h0 || SrcData2 !== 16'h0) begin
      errs++; $display("FAIL reset_force: got %h/%h exp 0000/0000", SrcData1, SrcData2);
    end
    tick();
    rst_n = 1'b1; Wordline = 16'h0;
    for (int r = 0; r < 16; r++) begin
      SrcReg1 = 4'(r); SrcReg2 = 4'(15 - r);
      #1;
      vecs++;
      if (SrcData1 !== 16'h0 || SrcData2 !== 16'h0) begin
        errs++; $display("FAIL reset_regs r%0d: got %h/%h exp 0000/0000", r, SrcData1, SrcData2);
      end
    end
    vecs++;
    if (wl_err !== 1'b0) begin
      errs++; $display("FAIL reset_err: got %b exp 0", wl_err);
    end
  endtask

  task automatic test_write_read();
    Wordline = 16'h0020; DstData = 16'hBEEF;
    tick();
    Wordline = 16'h0; SrcReg1 = 4'd5; SrcReg2 = 4'd4;
    #1;
    vecs++;
    if (SrcData1 !== 16'hBEEF || SrcData2 !== 16'h0) begin
      errs++; $display("FAIL write_read: got %h/%h exp beef/0000", SrcData1, SrcData2);
    end
  endtask

  task automatic test_bypass();
    Wordline = 16'h0008; DstData = 16'h1111;
    tick();
    Wordline = 16'h0008; DstData = 16'h2222; SrcReg1 = 4'd3; SrcReg2 = 4'd3;
    #1;
    vecs++;
    if (SrcData1 !== 16'h2222 || SrcData2 !== 16'h2222) begin
      errs++; $display("FAIL bypass_same: got %h/%h exp 2222/2222", SrcData1, SrcData2);
    end
    tick();
    Wordline = 16'h0;
    #1;
    vecs++;
    if (SrcData1 !== 16'h2222 || SrcData2 !== 16'h2222) begin
      errs++; $display("FAIL bypass_after: got %h/%h exp 2222/2222", SrcData1, SrcData2);
    end
  endtask

  task automatic test_multihot();
    Wordline = 16'h0002; DstData = 16'hAAAA; tick();
    Wordline = 16'h0004; DstData = 16'h5555; tick();
    Wordline = 16'h0006; DstData = 16'hFFFF; SrcReg1 = 4'd1; SrcReg2 = 4'd2;
    #1;
    vecs++;
    if (SrcData1 !== 16'hAAAA || SrcData2 !== 16'h5555) begin
      errs++; $display("FAIL multihot_nobypass: got %h/%h exp aaaa/5555", SrcData1, SrcData2);
    end
    tick();
    Wordline = 16'h0;
    #1;
    vecs++;
    if (SrcData1 !== 16'hAAAA || SrcData2 !== 16'h5555 || wl_err !== 1'b1) begin
      errs++; $display("FAIL multihot_store: got %h/%h err=%b exp aaaa/5555 err=1", SrcData1, SrcData2, wl_err);
    end
    Wordline = 16'h0100; DstData = 16'h0BAD; tick();
    Wordline = 16'h0;
    #1;
    vecs++;
    if (wl_err !== 1'b1) begin
      errs++; $display("FAIL multihot_sticky: got %b exp 1", wl_err);
    end
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    #1;
    vecs++;
    if (wl_err !== 1'b0) begin
      errs++; $display("FAIL multihot_clear: got %b exp 0", wl_err);
    end
  endtask

  task automatic test_r0();
    Wordline = 16'h0001; DstData = 16'h1234; SrcReg1 = 4'd0; SrcReg2 = 4'd0;
    #1;
    vecs++;
    if (SrcData1 !== 16'h0 || SrcData2 !== 16'h0) begin
      errs++; $display("FAIL r0_bypass: got %h/%h exp 0000/0000", SrcData1, SrcData2);
    end
    tick();
    Wordline = 16'h0;
    #1;
    vecs++;
    if (SrcData1 !== 16'h0 || wl_err !== 1'b0) begin
      errs++; $display("FAIL r0_store: got %h err=%b exp 0000 err=0", SrcData1, wl_err);
    end
  endtask

  task automatic test_reset_midwrite();
    Wordline = 16'h8000; DstData = 16'h3C3C; tick();
    rst_n = 1'b0; Wordline = 16'h8000; DstData = 16'hA5A5; tick();
    rst_n = 1'b1; Wordline = 16'h0; SrcReg1 = 4'd15;
    #1;
    vecs++;
    if (SrcData1 !== 16'h0) begin
      errs++; $display("FAIL reset_midwrite: got %h exp 0000", SrcData1);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      int k;
      k = $urandom_range(0, 99);
      rst_n    = (k < 3) ? 1'b0 : 1'b1;
      if (k < 25)      Wordline = 16'h0;
      else if (k < 32) Wordline = 16'($urandom) | 16'h0101;
      else             Wordline = 16'h1 << $urandom_range(0, 15);
      DstData = 16'($urandom);
      SrcReg1 = 4'($urandom_range(0, 15));
      SrcReg2 = ($urandom_range(0, 3) == 0) ? SrcReg1 : 4'($urandom_range(0, 15));
      #1;
      vecs++;
      if (SrcData1 !== exp_rd(SrcReg1) || SrcData2 !== exp_rd(SrcReg2) || wl_err !== merr) begin
        errs++;
        $display("FAIL random n%0d: got %h/%h err=%b exp %h/%h err=%b", n,
                 SrcData1, SrcData2, wl_err, exp_rd(SrcReg1), exp_rd(SrcReg2), merr);
      end
      tick();
    end
  endtask

  initial begin
    vecs = 0; errs = 0; merr = 1'b0;
    for (int i = 0; i < 16; i++) model[i] = 16'h0;
    rst_n = 1'b0; Wordline = 16'h0; DstData = 16'h0; SrcReg1 = 4'd0; SrcReg2 = 4'd0;
    test_reset();
    test_write_read();
    test_bypass();
    test_multihot();
    test_r0();
    test_reset_midwrite();
    rst_n = 1'b0; Wordline = 16'h0; tick(); rst_n = 1'b1;
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
`default_nettype wire
